// File: rtl/lcd_nibble_ctrl.sv
// HD44780 4-bit write sequencer: takes one byte (or single nibble) plus RS from
// the CPU register decode and produces timed E/RS/DB[7:4] with a busy flag.
module lcd_nibble_ctrl #(
  parameter int SETUP_CYC     = 2,
  parameter int E_CYC         = 13,
  parameter int HOLD_CYC      = 14,
  parameter int EXEC_CYC      = 1080,
  parameter int LONG_EXEC_CYC = 44280,
  parameter int CNT_W         = 16
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic       wr_rs,
  input  logic       wr_nib,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       drop,
  output logic       lcd_e,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [3:0] lcd_db
);

  // Phase counters are loaded with N-1; a phase ends on the edge where it reads 0.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_LD     = CNT_W'(E_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_EXEC_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    EHI   = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic [3:0]       db_q, db_d;
  logic [3:0]       lo_q, lo_d;     // low nibble waiting for the second transfer
  logic             pend_q, pend_d; // second nibble still to be sent
  logic             long_q, long_d; // clear/home command needs the long exec wait
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // Next-state logic: phase sequencing, bus updates and write acceptance/drop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    drop_d  = 1'b0;
    e_d     = e_q;
    rs_d    = rs_q;
    db_d    = db_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    long_d  = long_q;

    // A write that lands while busy is discarded; only the pulse records it.
    if (wr && busy_q) begin
      drop_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (wr) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          busy_d  = 1'b1;
          rs_d    = wr_rs;
          db_d    = wr_nib ? wr_data[3:0] : wr_data[7:4];
          lo_d    = wr_data[3:0];
          pend_d  = !wr_nib;
          long_d  = !wr_rs && !wr_nib && (wr_data[7:2] == 6'd0);
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_d = EHI;
          cnt_d   = E_LD;
          e_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      EHI: begin
        if (cnt_zero) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          e_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          if (pend_q) begin
            // RS stays put; only the data nibble changes for the second transfer.
            state_d = SETUP;
            cnt_d   = SETUP_LD;
            db_d    = lo_q;
            pend_d  = 1'b0;
          end else begin
            state_d = EXEC;
            cnt_d   = long_q ? LONG_LD : EXEC_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      EXEC: begin
        if (cnt_zero) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        e_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops E and discards any pending byte.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= 4'd0;
      lo_q    <= 4'd0;
      pend_q  <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
      long_q  <= long_d;
    end
  end

  assign busy   = busy_q;
  assign drop   = drop_q;
  assign lcd_e  = e_q;
  assign lcd_rw = 1'b0;
  assign lcd_rs = rs_q;
  assign lcd_db = db_q;

endmodule

// File: tb/tb_lcd_nibble_ctrl.sv
// Bench for lcd_nibble_ctrl: waveform-level reference model plus directed scenarios.
module tb_lcd_nibble_ctrl;

  localparam int S = 2;
  localparam int E = 3;
  localparam int H = 2;
  localparam int X = 10;
  localparam int L = 50;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       wr      = 1'b0;
  logic       wr_rs   = 1'b0;
  logic       wr_nib  = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic       busy, drop, lcd_e, lcd_rw, lcd_rs;
  logic [3:0] lcd_db;

  int tests = 0;
  int fails = 0;

  lcd_nibble_ctrl #(
    .SETUP_CYC(S), .E_CYC(E), .HOLD_CYC(H), .EXEC_CYC(X), .LONG_EXEC_CYC(L), .CNT_W(16)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .wr(wr), .wr_rs(wr_rs), .wr_nib(wr_nib),
    .wr_data(wr_data), .busy(busy), .drop(drop), .lcd_e(lcd_e), .lcd_rw(lcd_rw),
    .lcd_rs(lcd_rs), .lcd_db(lcd_db)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: on acceptance, the whole remaining waveform is expanded into
  // one frame per cycle; busy is simply "a frame was consumed this cycle".
  typedef struct packed {
    logic       e;
    logic [3:0] db;
  } frame_t;

  frame_t     q[$];
  logic       exp_busy = 1'b0;
  logic       exp_drop = 1'b0;
  logic       exp_e    = 1'b0;
  logic       exp_rs   = 1'b0;
  logic [3:0] exp_db   = 4'd0;

  task automatic push_nibble(input logic [3:0] d);
    for (int i = 0; i < S; i++) q.push_back('{e: 1'b0, db: d});
    for (int i = 0; i < E; i++) q.push_back('{e: 1'b1, db: d});
    for (int i = 0; i < H; i++) q.push_back('{e: 1'b0, db: d});
  endtask

  initial begin
    forever begin
      @(posedge sys_clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        exp_busy = 1'b0; exp_drop = 1'b0; exp_e = 1'b0; exp_rs = 1'b0; exp_db = 4'd0;
      end else begin
        exp_drop = wr && exp_busy;
        if (wr && !exp_busy) begin
          int xlen;
          logic [3:0] last;
          exp_rs = wr_rs;
          if (wr_nib) begin
            push_nibble(wr_data[3:0]);
          end else begin
            push_nibble(wr_data[7:4]);
            push_nibble(wr_data[3:0]);
          end
          last = wr_data[3:0];
          xlen = (!wr_rs && !wr_nib && wr_data < 8'd4) ? L : X;
          for (int i = 0; i < xlen; i++) q.push_back('{e: 1'b0, db: last});
        end
        if (q.size() > 0) begin
          frame_t f;
          f = q.pop_front();
          exp_busy = 1'b1; exp_e = f.e; exp_db = f.db;
        end else begin
          exp_busy = 1'b0; exp_e = 1'b0;
        end
      end
    end
  end

  // Compare every cycle against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (rst_n) begin
        check("busy",   busy,   exp_busy);
        check("drop",   drop,   exp_drop);
        check("lcd_e",  lcd_e,  exp_e);
        check("lcd_rs", lcd_rs, exp_rs);
        check("lcd_db", lcd_db, exp_db);
        check("lcd_rw", lcd_rw, 0);
      end
    end
  end

  int drop_cnt = 0;
  initial begin
    forever begin
      @(negedge sys_clk);
      if (drop) drop_cnt++;
    end
  end

  logic [63:0] emask;
  int          dbh[0:64];

  // Called at a falling edge: holds wr across exactly one rising edge.
  task automatic do_write(input logic rs, input logic nib, input logic [7:0] d);
    #1;
    wr_rs = rs; wr_nib = nib; wr_data = d; wr = 1'b1;
    @(negedge sys_clk);
    #1;
    wr = 1'b0;
  endtask

  // Counts busy cycles and records E/DB per cycle; returns at a falling edge with busy low.
  task automatic measure(output int n);
    n = 0;
    emask = '0;
    while (busy && n < 1000) begin
      n++;
      if (n <= 64) begin
        emask[n-1] = lcd_e;
        dbh[n]     = lcd_db;
      end
      @(negedge sys_clk);
    end
    if (n >= 1000) check("busy_timeout", n, 0);
  endtask

  initial begin
    int n;
    int d0;
    repeat (3) @(negedge sys_clk);
    check("rst_busy", busy, 0);
    check("rst_e", lcd_e, 0);
    check("rst_db", lcd_db, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_drop", drop, 0);
    #1 rst_n = 1'b1;
    @(negedge sys_clk);

    // Byte 0x41 as data.
    do_write(1'b1, 1'b0, 8'h41);
    measure(n);
    check("s1_busy_len", n, 24);
    check("s1_emask", int'(emask[31:0]), 32'hE1C);
    check("s1_db_c1", dbh[1], 4);
    check("s1_db_c7", dbh[7], 4);
    check("s1_db_c8", dbh[8], 1);
    check("s1_db_c24", dbh[24], 1);

    // Single nibble 0x?3 as instruction.
    do_write(1'b0, 1'b1, 8'hF3);
    measure(n);
    check("s2_busy_len", n, 17);
    check("s2_emask", int'(emask[31:0]), 32'h1C);
    check("s2_db_held", lcd_db, 3);
    check("s2_rs_held", lcd_rs, 0);

    // Clear display takes the long wait; 0x00 as data does not.
    do_write(1'b0, 1'b0, 8'h01);
    measure(n);
    check("s3_clear_len", n, 64);
    check("s3_emask", int'(emask[31:0]), 32'hE1C);
    check("s3_db_c1", dbh[1], 0);
    check("s3_db_c8", dbh[8], 1);
    do_write(1'b1, 1'b0, 8'h00);
    measure(n);
    check("s3_zero_data_len", n, 24);

    // Write during busy is dropped and does not disturb the transfer.
    d0 = drop_cnt;
    do_write(1'b1, 1'b0, 8'h41);
    fork
      measure(n);
      begin
        repeat (3) @(negedge sys_clk);
        #1;
        wr_data = 8'hA5; wr_rs = 1'b0; wr_nib = 1'b0; wr = 1'b1;
        @(negedge sys_clk);
        #1 wr = 1'b0;
      end
    join
    check("s4_busy_len", n, 24);
    check("s4_emask", int'(emask[31:0]), 32'hE1C);
    check("s4_db_c8", dbh[8], 1);
    check("s4_drop_pulses", drop_cnt - d0, 1);

    // Back-to-back: write in the first not-busy cycle.
    do_write(1'b0, 1'b0, 8'h28);
    measure(n);
    check("s5_busy_len", n, 24);
    check("s5_db_c1", dbh[1], 2);
    check("s5_db_c8", dbh[8], 8);

    // Reset during E high.
    do_write(1'b1, 1'b0, 8'h5A);
    repeat (2) @(negedge sys_clk);
    check("s6_e_before_rst", lcd_e, 1);
    #1 rst_n = 1'b0;
    #1;
    check("s6_rst_e", lcd_e, 0);
    check("s6_rst_busy", busy, 0);
    check("s6_rst_db", lcd_db, 0);
    check("s6_rst_rs", lcd_rs, 0);
    @(negedge sys_clk);
    #1 rst_n = 1'b1;
    @(negedge sys_clk);
    check("s6_idle_busy", busy, 0);
    do_write(1'b1, 1'b0, 8'h41);
    measure(n);
    check("s6_after_len", n, 24);
    check("s6_after_emask", int'(emask[31:0]), 32'hE1C);

    repeat (3) @(negedge sys_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

endmodule
